// File: rtl/i2c_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_burst_seq
// Purpose  : EEPROM burst write/read sequencer for i2c_ctrl with a read-back
//            buffer replayed to the display. Optional read-back checking is
//            enabled with the I2C_SEQ_VERIFY_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_burst_seq #(
    parameter int                DATA_NUM      = 10,
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'h005A,
    parameter logic [7:0]        DATA_INIT     = 8'h01,
    parameter logic [7:0]        DATA_STEP     = 8'h01,
    parameter int                CNT_START_MAX = 200_000,
    parameter int                CNT_WAIT_MAX  = 25_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              write,
    input  logic              read,
    input  logic              i2c_end,
    input  logic [7:0]        rd_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic              i2c_start,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt
);

    localparam int C_N_W   = $clog2(DATA_NUM + 1);
    localparam int C_BUF_D = 1 << C_N_W;
    localparam int C_CS_W  = (CNT_START_MAX > 1) ? $clog2(CNT_START_MAX) : 1;
    localparam int C_CW_W  = (CNT_WAIT_MAX > 1) ? $clog2(CNT_WAIT_MAX) : 1;

    localparam logic [C_N_W-1:0]  C_N_LAST  = C_N_W'(DATA_NUM - 1);
    localparam logic [C_N_W-1:0]  C_N_ALL   = C_N_W'(DATA_NUM);
    localparam logic [C_CS_W-1:0] C_CS_LAST = C_CS_W'(CNT_START_MAX - 1);
    localparam logic [C_CW_W-1:0] C_CW_LAST = C_CW_W'(CNT_WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    state_t              r_state;
    logic [C_CS_W-1:0]   r_cnt_start;
    logic [C_CW_W-1:0]   r_cnt_wait;
    logic [C_N_W-1:0]    r_start_num;
    logic [C_N_W-1:0]    r_byte_num;
    logic [C_N_W-1:0]    r_show_num;
    logic [7:0]          r_buf [C_BUF_D];
    logic                w_buf_we;
    logic                w_rd_req;

    assign w_buf_we = (r_state == S_RD) && i2c_end;
    assign w_rd_req = (r_state == S_IDLE) && read && !write;

    // Buffer is bounded by the byte counter, so no reset and no full logic.
    always_ff @(posedge sys_clk) begin
        if (w_buf_we) begin
            r_buf[r_byte_num] <= rd_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt_start <= '0;
            r_cnt_wait  <= '0;
            r_start_num <= '0;
            r_byte_num  <= '0;
            r_show_num  <= '0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            i2c_start   <= 1'b0;
            byte_addr   <= BASE_ADDR;
            wr_data     <= DATA_INIT;
            disp_data   <= 8'h00;
            disp_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            i2c_start  <= 1'b0;
            disp_valid <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (write || read) begin
                        r_state     <= write ? S_WR : S_RD;
                        wr_en       <= write;
                        rd_en       <= !write;
                        busy        <= 1'b1;
                        r_cnt_start <= '0;
                        r_start_num <= '0;
                        r_byte_num  <= '0;
                        byte_addr   <= BASE_ADDR;
                        wr_data     <= DATA_INIT;
                    end
                end
                S_WR, S_RD: begin
                    // Start guard: a late final i2c_end must not trigger an extra start.
                    if (r_cnt_start == C_CS_LAST) begin
                        r_cnt_start <= '0;
                        if (r_start_num < C_N_ALL) begin
                            i2c_start   <= 1'b1;
                            r_start_num <= r_start_num + 1'b1;
                        end
                    end else begin
                        r_cnt_start <= r_cnt_start + 1'b1;
                    end

                    if (i2c_end) begin
                        r_byte_num <= r_byte_num + 1'b1;
                        byte_addr  <= byte_addr + 1'b1;
                        if (r_state == S_WR) begin
                            wr_data <= wr_data + DATA_STEP;
                        end
                        // Burst complete: address/data park at their base values.
                        if (r_byte_num == C_N_LAST) begin
                            wr_en     <= 1'b0;
                            rd_en     <= 1'b0;
                            byte_addr <= BASE_ADDR;
                            wr_data   <= DATA_INIT;
                            if (r_state == S_WR) begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_state    <= S_SHOW;
                                r_cnt_wait <= '0;
                                r_show_num <= '0;
                            end
                        end
                    end
                end
                S_SHOW: begin
                    if (r_show_num == C_N_ALL) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (r_cnt_wait == C_CW_LAST) begin
                        r_cnt_wait <= '0;
                        disp_data  <= r_buf[r_show_num];
                        disp_valid <= 1'b1;
                        r_show_num <= r_show_num + 1'b1;
                    end else begin
                        r_cnt_wait <= r_cnt_wait + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef I2C_SEQ_VERIFY_EN
    logic [7:0] r_exp_data;

    // Expected pattern advances once per received byte, independent of wr_data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt    <= 8'h00;
            r_exp_data <= DATA_INIT;
        end else if (w_rd_req) begin
            err_cnt    <= 8'h00;
            r_exp_data <= DATA_INIT;
        end else if (w_buf_we) begin
            r_exp_data <= r_exp_data + DATA_STEP;
            if ((rd_data != r_exp_data) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = w_rd_req;
    assign err_cnt  = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_burst_seq
// Purpose  : Self-checking bench for i2c_burst_seq with a cycle-based model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_burst_seq;

    localparam int          N    = 4;
    localparam int          SMAX = 20;
    localparam int          WMAX = 8;
    localparam logic [15:0] BASE = 16'h005A;
    localparam logic [7:0]  INIT = 8'h01;
    localparam logic [7:0]  STEP = 8'h01;
`ifdef I2C_SEQ_VERIFY_EN
    localparam logic [7:0]  EXP_ERR = 8'd2;
`else
    localparam logic [7:0]  EXP_ERR = 8'd0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        write     = 1'b0;
    logic        read      = 1'b0;
    logic        i2c_end   = 1'b0;
    logic [7:0]  rd_data   = 8'h00;
    logic        wr_en, rd_en, i2c_start, disp_valid, busy, done;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data, disp_data, err_cnt;

    i2c_burst_seq #(
        .DATA_NUM(N), .ADDR_W(16), .BASE_ADDR(BASE), .DATA_INIT(INIT),
        .DATA_STEP(STEP), .CNT_START_MAX(SMAX), .CNT_WAIT_MAX(WMAX)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .write(write), .read(read),
        .i2c_end(i2c_end), .rd_data(rd_data), .wr_en(wr_en), .rd_en(rd_en),
        .i2c_start(i2c_start), .byte_addr(byte_addr), .wr_data(wr_data),
        .disp_data(disp_data), .disp_valid(disp_valid), .busy(busy),
        .done(done), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural i2c_ctrl: i2c_end 10 cycles after a start
    logic [7:0] rd_tab [N];
    int late_extra = 0;
    int r_cd  = 0;
    int r_idx = 0;

    always @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cd    = 0;
            r_idx   = 0;
            i2c_end = 1'b0;
        end else begin
            i2c_end = 1'b0;
            if (r_cd > 0) begin
                r_cd--;
                if (r_cd == 0) begin
                    i2c_end = 1'b1;
                    rd_data = rd_tab[r_idx];
                    r_idx   = (r_idx + 1) % N;
                end
            end
            if (i2c_start) r_cd = (r_idx == N - 1) ? 10 + late_extra : 10;
        end
    end

    // ---------------- model: outputs derived from cycle offsets since entry
    typedef enum int {M_IDLE, M_WR, M_RD, M_SHOW} mode_t;
    mode_t      m_mode  = M_IDLE;
    int         cyc     = 0;
    int         m_entry = 0;
    int         m_ends  = 0;
    int         m_show  = 0;
    int         m_done  = -1;
    logic [7:0] m_buf [N];
    logic [7:0] m_disp  = 8'h00;
    logic [7:0] m_err   = 8'h00;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_mode = M_IDLE;
            m_done = -1;
            m_disp = 8'h00;
            m_err  = 8'h00;
        end else begin
            cyc++;
            case (m_mode)
                M_IDLE: begin
                    if (write) begin
                        m_mode = M_WR; m_entry = cyc; m_ends = 0;
                    end else if (read) begin
                        m_mode = M_RD; m_entry = cyc; m_ends = 0;
`ifdef I2C_SEQ_VERIFY_EN
                        m_err = 8'h00;
`endif
                    end
                end
                M_WR, M_RD: begin
                    if (i2c_end) begin
                        if (m_mode == M_RD) begin
                            m_buf[m_ends] = rd_data;
`ifdef I2C_SEQ_VERIFY_EN
                            if (rd_data != 8'(INIT + m_ends * STEP) && m_err != 8'hFF) m_err++;
`endif
                        end
                        m_ends++;
                        if (m_ends == N) begin
                            if (m_mode == M_WR) begin
                                m_mode = M_IDLE; m_done = cyc;
                            end else begin
                                m_mode = M_SHOW; m_show = cyc;
                            end
                        end
                    end
                end
                M_SHOW: begin
                    if (cyc == m_show + WMAX * N + 1) begin
                        m_mode = M_IDLE; m_done = cyc;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            if (m_mode == M_SHOW && cyc - m_show > 0 && (cyc - m_show) % WMAX == 0 &&
                (cyc - m_show) / WMAX <= N)
                m_disp = m_buf[(cyc - m_show) / WMAX - 1];
        end
    end

    always @(negedge sys_clk) begin
        logic        exp_start, exp_dv, in_xfer;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        int          d, ds;
        d         = cyc - m_entry;
        ds        = cyc - m_show;
        in_xfer   = (m_mode == M_WR) || (m_mode == M_RD);
        exp_start = in_xfer && d > 0 && d % SMAX == 0 && d / SMAX <= N;
        exp_dv    = (m_mode == M_SHOW) && ds > 0 && ds % WMAX == 0 && ds / WMAX <= N;
        exp_addr  = in_xfer ? 16'(BASE + m_ends) : BASE;
        exp_wd    = (m_mode == M_WR) ? 8'(INIT + m_ends * STEP) : INIT;
        check("m_busy",       32'(busy),       32'(m_mode != M_IDLE));
        check("m_wr_en",      32'(wr_en),      32'(m_mode == M_WR));
        check("m_rd_en",      32'(rd_en),      32'(m_mode == M_RD));
        check("m_i2c_start",  32'(i2c_start),  32'(exp_start));
        check("m_byte_addr",  32'(byte_addr),  32'(exp_addr));
        check("m_wr_data",    32'(wr_data),    32'(exp_wd));
        check("m_disp_valid", 32'(disp_valid), 32'(exp_dv));
        check("m_disp_data",  32'(disp_data),  32'(m_disp));
        check("m_done",       32'(done),       32'(cyc == m_done));
        check("m_err_cnt",    32'(err_cnt),    32'(m_err));
    end

    // ---------------- directed stimulus with literal expectations
    task automatic pulse(input logic w, input logic r);
        @(negedge sys_clk);
        write = w;
        read  = r;
        @(negedge sys_clk);
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic wait_for(input int which, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge sys_clk);
            if ((which == 0 && i2c_start) || (which == 1 && done) ||
                (which == 2 && disp_valid) || (which == 3 && byte_addr == 16'h005C)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [15:0] lit_addr [N];
    logic [7:0]  lit_data [N];
    bit          ok;
    int          cnt;
    time         t_prev;

    initial begin
        lit_addr = '{16'h005A, 16'h005B, 16'h005C, 16'h005D};
        lit_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        rd_tab   = '{8'h01, 8'h02, 8'h03, 8'h04};

        // reset values
        repeat (3) @(negedge sys_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(byte_addr), 32'h005A);
        check("rst_wdata", 32'(wr_data), 32'h01);
        check("rst_disp", 32'(disp_data), 32'h00);
        #2 sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // write burst
        pulse(1'b1, 1'b0);
        check("wr_en_after_req", 32'(wr_en), 32'd1);
        for (int k = 0; k < N; k++) begin
            wait_for(0, 60, ok);
            check("wr_start_seen", 32'(ok), 32'd1);
            check("wr_addr", 32'(byte_addr), 32'(lit_addr[k]));
            check("wr_data", 32'(wr_data), 32'(lit_data[k]));
        end
        wait_for(1, 60, ok);
        check("wr_done_seen", 32'(ok), 32'd1);
        check("wr_end_addr", 32'(byte_addr), 32'h005A);
        check("wr_end_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge sys_clk);

        // read then show
        pulse(1'b0, 1'b1);
        t_prev = 0;
        for (int k = 0; k < N; k++) begin
            wait_for(2, 200, ok);
            check("show_valid_seen", 32'(ok), 32'd1);
            check("show_disp", 32'(disp_data), 32'(lit_data[k]));
            if (k > 0) check("show_interval", 32'(($time - t_prev) / 10), 32'd8);
            t_prev = $time;
        end
        wait_for(1, 5, ok);
        check("show_done_seen", 32'(ok), 32'd1);
        check("show_end_busy", 32'(busy), 32'd0);
        check("show_err", 32'(err_cnt), 32'd0);
        repeat (3) @(negedge sys_clk);

        // late final i2c_end: no fifth start
        late_extra = 30;
        pulse(1'b1, 1'b0);
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge sys_clk);
            if (i2c_start) cnt++;
            if (done) ok = 1'b1;
        end
        check("late_done_seen", 32'(ok), 32'd1);
        check("late_start_count", 32'(cnt), 32'd4);
        late_extra = 0;
        repeat (3) @(negedge sys_clk);

        // simultaneous write+read, then read during WR
        pulse(1'b1, 1'b1);
        check("both_wr_en", 32'(wr_en), 32'd1);
        check("both_rd_en", 32'(rd_en), 32'd0);
        repeat (5) @(negedge sys_clk);
        pulse(1'b0, 1'b1);
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge sys_clk);
            if (rd_en) cnt++;
            if (done) ok = 1'b1;
        end
        check("both_done_seen", 32'(ok), 32'd1);
        check("both_rd_en_cycles", 32'(cnt), 32'd0);
        repeat (3) @(negedge sys_clk);

        // reset in the middle of a read burst
        pulse(1'b0, 1'b1);
        wait_for(3, 100, ok);
        check("mid_two_bytes", 32'(ok), 32'd1);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_addr", 32'(byte_addr), 32'h005A);
        check("mid_rst_disp", 32'(disp_data), 32'h00);
        #2 sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        pulse(1'b0, 1'b1);
        wait_for(0, 60, ok);
        check("mid_restart_seen", 32'(ok), 32'd1);
        check("mid_restart_addr", 32'(byte_addr), 32'h005A);
        wait_for(1, 300, ok);
        check("mid_restart_done", 32'(ok), 32'd1);
        repeat (3) @(negedge sys_clk);

        // corrupted read-back data
        rd_tab = '{8'h01, 8'hFF, 8'h03, 8'h00};
        pulse(1'b0, 1'b1);
        wait_for(1, 300, ok);
        check("verify_done_seen", 32'(ok), 32'd1);
        check("verify_err_cnt", 32'(err_cnt), 32'(EXP_ERR));
        repeat (3) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
